// File: rtl/dircc_multi_receive_handler.sv
// Multi-port receive handler for a DIRCC graph node.
// Round-robin arbitration over NUM_PORTS packet streams, a one-deep capture register
// (stage 1), and a weighted accumulate step (stage 2) that sorts packets into the
// current or next timestep window. advance drains the pipeline and steps time; done
// latches once the final timestep has collected all expected neighbour packets.
//
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   in_valid/in_ready                per-port handshake (in_ready is the one-hot grant)
//   in_data/in_t/in_weight           per-port packed payload, timestamp, edge weight
//   cfg_max_time, cfg_neighbour_count  final timestep, packets expected per timestep
//   advance, clear                   time-step request, synchronous return to reset state
//   cur_t, seen_now/next, acc_now/next  time and per-window counters/accumulators
//   err_count, busy, done            dropped packets, pipeline occupied, finished
module dircc_multi_receive_handler #(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned WEIGHT_W  = 8,
   parameter int unsigned ACC_W     = 32,
   parameter int unsigned T_W       = 16,
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned SATURATE  = 1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_PORTS-1:0]          in_valid,
   output logic [NUM_PORTS-1:0]          in_ready,
   input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
   input  logic [NUM_PORTS*T_W-1:0]      in_t,
   input  logic [NUM_PORTS*WEIGHT_W-1:0] in_weight,
   input  logic [T_W-1:0]                cfg_max_time,
   input  logic [CNT_W-1:0]              cfg_neighbour_count,
   input  logic                          advance,
   input  logic                          clear,
   output logic [T_W-1:0]                cur_t,
   output logic [CNT_W-1:0]              seen_now,
   output logic [CNT_W-1:0]              seen_next,
   output logic signed [ACC_W-1:0]       acc_now,
   output logic signed [ACC_W-1:0]       acc_next,
   output logic [15:0]                   err_count,
   output logic                          busy,
   output logic                          done
);

   localparam int unsigned RR_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned PROD_W = DATA_W + WEIGHT_W;
   localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

   state_e                     state_q, state_d;
   logic [RR_W-1:0]            rr_q, rr_d;
   logic                       s1_valid_q, s1_valid_d;
   logic signed [DATA_W-1:0]   s1_data_q, s1_data_d;
   logic [T_W-1:0]             s1_t_q, s1_t_d;
   logic signed [WEIGHT_W-1:0] s1_weight_q, s1_weight_d;
   logic [T_W-1:0]             cur_t_q, cur_t_d;
   logic [CNT_W-1:0]           seen_now_q, seen_now_d, seen_next_q, seen_next_d;
   logic signed [ACC_W-1:0]    acc_now_q, acc_now_d, acc_next_q, acc_next_d;
   logic [15:0]                err_q, err_d;

   logic [NUM_PORTS-1:0]       grant;
   logic [RR_W-1:0]            grant_idx;
   logic [RR_W-1:0]            scan_ptr;
   logic                       grant_found;
   logic                       xfer;
   logic                       upd, step;
   logic signed [PROD_W-1:0]   product;
   logic signed [ACC_W-1:0]    prod_ext;

   function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [ACC_W-1:0] b);
      logic [ACC_W:0] sum;
      sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
      // Top two bits differ only on signed overflow.
      if (SATURATE != 0 && sum[ACC_W] != sum[ACC_W-1]) return sum[ACC_W] ? AccMin : AccMax;
      return sum[ACC_W-1:0];
   endfunction

   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   // Round-robin: first asserted valid at or after rr_q.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_found = 1'b0;
      scan_ptr    = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         scan_ptr = RR_W'((32'(rr_q) + i) % NUM_PORTS);
         if (!grant_found && in_valid[scan_ptr]) begin
            grant_found     = 1'b1;
            grant[scan_ptr] = 1'b1;
            grant_idx       = scan_ptr;
         end
      end
   end

   // Gating on reset_n and clear keeps a packet from handshaking and then being lost.
   assign in_ready = (state_q == StRun && reset_n && !clear) ? grant : '0;
   assign xfer     = |in_ready;

   // Stage 2 works directly on the stage-1 register, so it is occupied exactly when
   // stage 1 holds a packet.
   assign product  = s1_data_q * s1_weight_q;
   assign prod_ext = ACC_W'(product);

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      s1_valid_d  = xfer;
      s1_data_d   = s1_data_q;
      s1_t_d      = s1_t_q;
      s1_weight_d = s1_weight_q;
      cur_t_d     = cur_t_q;
      seen_now_d  = seen_now_q;
      seen_next_d = seen_next_q;
      acc_now_d   = acc_now_q;
      acc_next_d  = acc_next_q;
      err_d       = err_q;
      upd         = 1'b0;
      step        = 1'b0;

      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (in_ready[i]) begin
            s1_data_d   = in_data[i*DATA_W +: DATA_W];
            s1_t_d      = in_t[i*T_W +: T_W];
            s1_weight_d = in_weight[i*WEIGHT_W +: WEIGHT_W];
         end
      end
      if (xfer) rr_d = (32'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + 1'b1;

      if (state_q != StDone) begin
         if (s1_valid_q) begin
            upd = 1'b1;
            if (s1_t_q == cur_t_q) begin
               seen_now_d = cnt_inc(seen_now_q);
               acc_now_d  = acc_add(acc_now_q, prod_ext);
            end else if (s1_t_q == cur_t_q + T_W'(1)) begin
               seen_next_d = cnt_inc(seen_next_q);
               acc_next_d  = acc_add(acc_next_q, prod_ext);
            end else begin
               err_d = (&err_q) ? err_q : err_q + 16'd1;
            end
         end else if (state_q == StDrain) begin
            step        = 1'b1;
            cur_t_d     = cur_t_q + T_W'(1);
            seen_now_d  = seen_next_q;
            acc_now_d   = acc_next_q;
            seen_next_d = '0;
            acc_next_d  = '0;
            state_d     = StRun;
         end
         if (state_q == StRun && advance) state_d = StDrain;
         if ((upd || step) && cur_t_d == cfg_max_time && seen_now_d == cfg_neighbour_count)
            state_d = StDone;
      end

      if (clear) begin
         state_d     = StRun;
         rr_d        = '0;
         s1_valid_d  = 1'b0;
         cur_t_d     = '0;
         seen_now_d  = '0;
         seen_next_d = '0;
         acc_now_d   = '0;
         acc_next_d  = '0;
         err_d       = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StRun;
         rr_q        <= '0;
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_t_q      <= '0;
         s1_weight_q <= '0;
         cur_t_q     <= '0;
         seen_now_q  <= '0;
         seen_next_q <= '0;
         acc_now_q   <= '0;
         acc_next_q  <= '0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         s1_valid_q  <= s1_valid_d;
         s1_data_q   <= s1_data_d;
         s1_t_q      <= s1_t_d;
         s1_weight_q <= s1_weight_d;
         cur_t_q     <= cur_t_d;
         seen_now_q  <= seen_now_d;
         seen_next_q <= seen_next_d;
         acc_now_q   <= acc_now_d;
         acc_next_q  <= acc_next_d;
         err_q       <= err_d;
      end
   end

   assign cur_t     = cur_t_q;
   assign seen_now  = seen_now_q;
   assign seen_next = seen_next_q;
   assign acc_now   = acc_now_q;
   assign acc_next  = acc_next_q;
   assign err_count = err_q;
   assign busy      = s1_valid_q;
   assign done      = (state_q == StDone);

endmodule

// File: tb/tb_dircc_multi_receive_handler.sv
module tb_dircc_multi_receive_handler;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [3:0] in_valid = '0;
   logic [63:0] in_data = '0;
   logic [63:0] in_t = '0;
   logic [31:0] in_weight = '0;
   logic [15:0] cfg_max_time = 16'hFFFF;
   logic [7:0] cfg_neighbour_count = 8'd200;
   logic advance = 1'b0;
   logic clear = 1'b0;

   logic [3:0] in_ready, s_in_ready, w_in_ready;
   logic [15:0] cur_t, s_cur_t, w_cur_t;
   logic [7:0] seen_now, seen_next, s_seen_now, s_seen_next, w_seen_now, w_seen_next;
   logic signed [31:0] acc_now, acc_next;
   logic signed [15:0] s_acc_now, s_acc_next, w_acc_now, w_acc_next;
   logic [15:0] err_count, s_err_count, w_err_count;
   logic busy, done, s_busy, s_done, w_busy, w_done;

   int n_tests = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dircc_multi_receive_handler dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_t(in_t), .in_weight(in_weight), .cfg_max_time(cfg_max_time),
      .cfg_neighbour_count(cfg_neighbour_count), .advance(advance), .clear(clear),
      .cur_t(cur_t), .seen_now(seen_now), .seen_next(seen_next), .acc_now(acc_now),
      .acc_next(acc_next), .err_count(err_count), .busy(busy), .done(done)
   );

   dircc_multi_receive_handler #(.ACC_W(16), .SATURATE(1)) dut_sat (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_data(in_data), .in_t(in_t), .in_weight(in_weight), .cfg_max_time(cfg_max_time),
      .cfg_neighbour_count(cfg_neighbour_count), .advance(advance), .clear(clear),
      .cur_t(s_cur_t), .seen_now(s_seen_now), .seen_next(s_seen_next), .acc_now(s_acc_now),
      .acc_next(s_acc_next), .err_count(s_err_count), .busy(s_busy), .done(s_done)
   );

   dircc_multi_receive_handler #(.ACC_W(16), .SATURATE(0)) dut_wrap (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(w_in_ready),
      .in_data(in_data), .in_t(in_t), .in_weight(in_weight), .cfg_max_time(cfg_max_time),
      .cfg_neighbour_count(cfg_neighbour_count), .advance(advance), .clear(clear),
      .cur_t(w_cur_t), .seen_now(w_seen_now), .seen_next(w_seen_next), .acc_now(w_acc_now),
      .acc_next(w_acc_next), .err_count(w_err_count), .busy(w_busy), .done(w_done)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic set_port(input int p, input int t, input int d, input int w);
      in_t[p*16 +: 16]     = 16'(t);
      in_data[p*16 +: 16]  = 16'(d);
      in_weight[p*8 +: 8]  = 8'(w);
   endtask

   // ---------------- behavioural reference model ----------------
   localparam int MRun = 0, MDrain = 1, MDone = 2;
   int m_st, m_rr;
   longint m_cur, m_sn, m_snx, m_an, m_anx, m_err;
   bit m_pend;
   longint p_t, p_prod;

   function automatic longint sat32(input longint v);
      if (v > 64'sd2147483647) return 64'sd2147483647;
      if (v < -64'sd2147483648) return -64'sd2147483648;
      return v;
   endfunction

   task automatic model_reset();
      m_st = MRun; m_rr = 0; m_cur = 0; m_sn = 0; m_snx = 0; m_an = 0; m_anx = 0;
      m_err = 0; m_pend = 0;
   endtask

   task automatic model_apply(input longint t, input longint prod);
      if (t == m_cur) begin
         m_sn = (m_sn < 255) ? m_sn + 1 : 255;
         m_an = sat32(m_an + prod);
      end else if (t == ((m_cur + 1) % 65536)) begin
         m_snx = (m_snx < 255) ? m_snx + 1 : 255;
         m_anx = sat32(m_anx + prod);
      end else begin
         m_err = (m_err < 65535) ? m_err + 1 : 65535;
      end
   endtask

   typedef struct {
      int port; int t; int data; int weight;
      int e_sn; int e_snx; longint e_an; longint e_anx; int e_err;
   } vec_t;
   vec_t vecs[6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got 1, expected 0");
      $fatal(1);
   end

   initial begin
      int g, st0;
      longint exp_ready;

      // Cumulative expectations from a cleared start at cur_t = 0.
      vecs[0] = '{1, 0,     10,   2,   1, 0,  20,   0,      0};
      vecs[1] = '{2, 1,     -5,   3,   1, 1,  20,   -15,    0};
      vecs[2] = '{0, 5,     9,    9,   1, 1,  20,   -15,    1};
      vecs[3] = '{3, 0,     -100, -4,  2, 1,  420,  -15,    1};
      vecs[4] = '{0, 65535, 1,    1,   2, 1,  420,  -15,    2};
      vecs[5] = '{2, 1,     127,  -128, 2, 2, 420,  -16271, 2};

      // Reset: outputs zero, packets offered during reset are not accepted.
      for (int p = 0; p < 4; p++) set_port(p, 0, 10, 2);
      in_valid = 4'hF;
      tick(); tick();
      check("reset_in_ready", in_ready, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_seen_now", seen_now, 0);
      check("reset_acc_now", acc_now, 0);
      in_valid = 4'h0;
      reset_n = 1'b1;
      tick(); tick();
      check("post_reset_seen_now", seen_now, 0);
      check("post_reset_busy", busy, 0);

      // Four ports together: grants 0,1,2,3 in consecutive cycles.
      do_clear();
      in_valid = 4'hF;
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("rr_grant_%0d", k), in_ready, 1 << k);
         tick();
         in_valid[k] = 1'b0;
      end
      tick();
      check("rr_seen_now", seen_now, 4);
      check("rr_acc_now", acc_now, 80);

      // Table-driven single packets through the window rule.
      do_clear();
      foreach (vecs[i]) begin
         set_port(vecs[i].port, vecs[i].t, vecs[i].data, vecs[i].weight);
         in_valid = 4'(1 << vecs[i].port);
         #1;
         check($sformatf("vec%0d_ready", i), in_ready, 1 << vecs[i].port);
         tick();
         in_valid = 4'h0;
         #1;
         check($sformatf("vec%0d_ready_drop", i), in_ready, 0);
         tick();
         check($sformatf("vec%0d_seen_now", i), seen_now, vecs[i].e_sn);
         check($sformatf("vec%0d_seen_next", i), seen_next, vecs[i].e_snx);
         check($sformatf("vec%0d_acc_now", i), acc_now, vecs[i].e_an);
         check($sformatf("vec%0d_acc_next", i), acc_next, vecs[i].e_anx);
         check($sformatf("vec%0d_err", i), err_count, vecs[i].e_err);
      end

      // Next-window packet followed by advance and drain.
      do_clear();
      set_port(1, 1, -5, 3);
      in_valid = 4'b0010;
      tick();
      in_valid = 4'h0;
      tick();
      check("drain_pre_seen_next", seen_next, 1);
      advance = 1'b1;
      tick();
      advance = 1'b0;
      in_valid = 4'b0010;
      #1;
      check("drain_in_ready_zero", in_ready, 0);
      check("drain_cur_t_hold", cur_t, 0);
      in_valid = 4'h0;
      tick();
      check("drain_cur_t", cur_t, 1);
      check("drain_seen_now", seen_now, 1);
      check("drain_acc_now", acc_now, -15);
      check("drain_seen_next", seen_next, 0);

      // Reset while a packet sits in stage 1.
      set_port(2, 1, 7, 7);
      in_valid = 4'b0100;
      tick();
      in_valid = 4'h0;
      check("rst_mid_busy_before", busy, 1);
      reset_n = 1'b0;
      #1;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_cur_t", cur_t, 0);
      check("rst_mid_seen_now", seen_now, 0);
      check("rst_mid_acc_now", acc_now, 0);
      in_valid = 4'b0100;
      #1;
      check("rst_mid_in_ready", in_ready, 0);
      tick();
      in_valid = 4'h0;
      reset_n = 1'b1;
      tick(); tick();
      check("rst_mid_never_counted", seen_now, 0);

      // Accumulator saturation vs wrap on 16-bit accumulators.
      do_clear();
      set_port(0, 0, 32767, 1);
      in_valid = 4'b0001;
      tick(); tick(); tick(); tick();
      in_valid = 4'h0;
      tick(); tick();
      check("sat_acc_now", s_acc_now, 32767);
      check("wrap_acc_now", w_acc_now, -4);
      check("wide_acc_now", acc_now, 131068);
      check("sat_seen_now", s_seen_now, 4);

      // Done at final timestep once the expected count is reached.
      cfg_max_time = 16'd0;
      cfg_neighbour_count = 8'd2;
      do_clear();
      set_port(0, 0, 1, 1);
      set_port(1, 0, 1, 1);
      in_valid = 4'b0011;
      tick();
      in_valid = 4'b0010;
      tick();
      in_valid = 4'h0;
      check("done_early", done, 0);
      tick();
      check("done_set", done, 1);
      check("done_seen_now", seen_now, 2);
      set_port(2, 0, 1, 1);
      in_valid = 4'b0100;
      advance = 1'b1;
      #1;
      check("done_in_ready", in_ready, 0);
      tick();
      advance = 1'b0;
      in_valid = 4'h0;
      tick();
      check("done_hold", done, 1);
      check("done_cur_t_frozen", cur_t, 0);
      check("done_seen_frozen", seen_now, 2);
      do_clear();
      check("clear_done", done, 0);
      check("clear_seen_now", seen_now, 0);
      check("clear_acc_now", acc_now, 0);
      cfg_max_time = 16'hFFFF;
      cfg_neighbour_count = 8'd200;
      do_clear();

      // Randomised traffic against the reference model.
      model_reset();
      for (int cyc = 0; cyc < 2000; cyc++) begin
         in_valid = 4'($urandom_range(0, 15));
         for (int p = 0; p < 4; p++) begin
            int sel, tt;
            sel = $urandom_range(0, 3);
            tt = (sel == 0) ? int'(m_cur) : (sel == 1) ? int'(m_cur) + 1 :
                 (sel == 2) ? int'(m_cur) + 2 : int'($urandom_range(0, 65535));
            set_port(p, tt, int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)));
         end
         advance = ($urandom_range(0, 15) == 0);
         #1;
         g = -1;
         if (m_st == MRun)
            for (int k = 0; k < 4; k++)
               if (g < 0 && in_valid[(m_rr + k) % 4]) g = (m_rr + k) % 4;
         exp_ready = (g >= 0) ? (64'd1 << g) : 0;
         check("rnd_in_ready", in_ready, exp_ready);
         check("rnd_cur_t", cur_t, m_cur);
         check("rnd_seen_now", seen_now, m_sn);
         check("rnd_seen_next", seen_next, m_snx);
         check("rnd_acc_now", acc_now, m_an);
         check("rnd_acc_next", acc_next, m_anx);
         check("rnd_err", err_count, m_err);
         check("rnd_busy", busy, m_pend);
         tick();
         st0 = m_st;
         if (m_pend) begin
            model_apply(p_t, p_prod);
         end else if (st0 == MDrain) begin
            m_cur = (m_cur + 1) % 65536;
            m_sn = m_snx; m_an = m_anx; m_snx = 0; m_anx = 0;
            m_st = MRun;
         end
         if (st0 == MRun && advance) m_st = MDrain;
         m_pend = (g >= 0);
         if (g >= 0) begin
            p_t = in_t[g*16 +: 16];
            p_prod = longint'($signed(in_data[g*16 +: 16])) * longint'($signed(in_weight[g*8 +: 8]));
            m_rr = (g + 1) % 4;
         end
      end
      in_valid = 4'h0;
      advance = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
